ycr_cclk_gate_mc: RTL and testbench
===================================

# ycr_cclk_gate_mc

Parametrised multi-channel core clock-gate controller, successor to the fixed two-core/AES/FPU gate block. Generates NCH independently gated clocks from one ungated core clock. Each channel has a configurable mode, a programmable idle hold-off before gating, and wake-up on source request or masked interrupts. Sits in the core clock tree between the clock source and each gated consumer: cores, FPU, AES, accelerators.

## Interface
Parameters:
- NCH, 4: number of gated channels (1..16)
- NIRQ, 8: number of asynchronous wake interrupt lines
- HW, 4: hold-off counter width

Ports:
- core_clk_int  in  1  ungated core clock
- rst_n  in  1  asynchronous active-low reset; synchronised internally (async assert, sync deassert)
- cfg_mode  in  2*NCH  per-channel mode; ch i at [2i+1:2i]
- cfg_holdoff  in  HW*NCH  per-channel idle hold-off in cycles
- cfg_irq_mask  in  NIRQ*NCH  per-channel irq enable; 1 = line may wake channel
- dst_idle  in  NCH  1 = consumer idle, may be gated
- src_req  in  NCH  1 = source requests consumer clock
- irq_i  in  NIRQ  asynchronous interrupt lines
- stats_clr  in  NCH  1-cycle pulse, clears channel gated-cycle counter
- clk_out  out  NCH  gated clocks
- clk_enb  out  NCH  registered clock-enable status
- wakeup  out  NCH  1-cycle wake pulse to consumer
- gated_cnt  out  16*NCH  per-channel gated-cycle count

## Operation
- irq_i passes through a 2-flop synchroniser; wake_i = |(irq_ss & cfg_irq_mask[i]).
- Modes:
  - 00 always on
  - 01 auto-gate, wake on src_req only
  - 10 forced off
  - 11 auto-gate, wake on src_req or wake_i
- Per-channel FSM states: RUN, HOLD, GATED, WAKE. clk_enb = 0 only in GATED.
- RUN -> HOLD when mode is 01/11, dst_idle=1 and no wake condition; counter is loaded with cfg_holdoff.
- HOLD, counter decrements each cycle:
  - returns to RUN if dst_idle=0 or a wake condition is present
  - goes to GATED when the counter is 0 and dst_idle=1
- Hold-off of 0: RUN -> HOLD -> GATED, clock stops 2 cycles after dst_idle is sampled.
- GATED -> WAKE on a wake condition, or when mode changes to 00.
- WAKE -> RUN unconditionally. wakeup=1 during WAKE only.
- Mode 10 from any state -> GATED next cycle; wake conditions are ignored; no wakeup pulse.
- Leaving mode 10 for 00/01/11 -> WAKE next cycle.
- Simultaneous dst_idle=1 and src_req=1: request wins, channel stays RUN.
- Channels are fully independent; no ordering between channels.

## Timing
- Reset values:
  - all FSMs RUN
  - clk_enb = all ones, so clocks run during reset
  - wakeup = 0
  - gated_cnt = 0
  - synchroniser flops = 0
- Gating latency, with dst_idle first sampled high at edge T and hold-off H: clk_enb falls at edge T+H+2.
- Wake latency from src_req: GATED -> WAKE at the next edge; clk_enb high one cycle later; first gated clock edge 2 cycles after src_req is sampled.
- Wake latency from irq_i: 2 extra cycles for synchronisation.
- clk_out is glitch-free. Enable is applied through a latch-based ctech_clk_gate cell (GATE=clk_enb, CLK=core_clk_int).
- Reset mid-operation: all channels return to RUN asynchronously, so clocks resume immediately.

## Configuration
- YCR_CCLK_STATS_EN defined:
  - gated_cnt[i] increments each cycle clk_enb[i]=0
  - saturates at 16'hFFFF
  - stats_clr[i] clears it to 0; clear has priority over increment
- Not defined: gated_cnt tied to 0, stats_clr ignored, no counter flops.

## Structure
- Shared package ycr_cclk_pkg holds:
  - mode enum: CCLK_ON, CCLK_AUTO, CCLK_OFF, CCLK_AUTO_IRQ
  - FSM state enum
  - stats width constant (16)
- One sub-module, ycr_cclk_gate_ch: single-channel FSM, hold-off counter, stats counter and clock-gate cell, instantiated NCH times in a generate loop.
- Top-level logic: reset sync, irq synchroniser, per-channel wake_i reduction.

## Test plan
- Reset with all modes 00: clk_enb=4'hF, clocks toggle, wakeup=0, gated_cnt=0.
- Ch0 mode 01, holdoff 3, dst_idle raised at T: clk_enb[0] falls at T+5. Then src_req pulse: wakeup[0] pulses and clk_enb[0] returns 2 cycles later.
- Ch1 mode 11, mask bit 2 set, gated; irq_i[2] pulses for 1 cycle: wakeup[1] 3 cycles later. Repeat with mask bit clear: no wake.
- Ch2 mode 01 in HOLD (holdoff 5), dst_idle drops at count 2: back to RUN, clk_enb stays 1.
- Ch3 switched to mode 10 while src_req=1: gated next cycle, no wakeup. Switch to 00: wakeup pulse, clock resumes.
- With YCR_CCLK_STATS_EN, ch0 gated for 20 cycles: gated_cnt[15:0]=20. stats_clr in the same cycle as an increment yields 0.

Source files
------------

// File: rtl/ycr_cclk_pkg.sv
// Shared types and constants for the multi-channel core clock-gate controller.
package ycr_cclk_pkg;

    localparam int unsigned CCLK_STATS_W = 16;

    typedef enum logic [1:0] {
        CCLK_ON       = 2'b00,
        CCLK_AUTO     = 2'b01,
        CCLK_OFF      = 2'b10,
        CCLK_AUTO_IRQ = 2'b11
    } cclk_mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } cclk_state_e;

    function automatic logic cclk_is_auto(input cclk_mode_e mode);
        return (mode == CCLK_AUTO) || (mode == CCLK_AUTO_IRQ);
    endfunction

endpackage

// File: rtl/ctech_clk_gate.sv
// Behavioural model of the latch-based integrated clock-gate cell.
module ctech_clk_gate (
    input  logic CLK,
    input  logic GATE,
    output logic GCLK
);
    logic en_lat;

    // Transparent while CLK is low so the enable can only change between pulses.
    always_latch begin
        if (!CLK) en_lat = GATE;
    end

    assign GCLK = CLK & en_lat;

endmodule

// File: rtl/ycr_cclk_gate_ch.sv
// One gated clock channel: gating FSM, hold-off timer, optional stats counter, gate cell.
// Define YCR_CCLK_STATS_EN to build the gated-cycle counter.
//
// state | meaning
// RUN   | clock running, consumer active or mode always-on
// HOLD  | consumer idle, hold-off timer counting down to 0
// GATED | clock stopped, waiting for a wake condition or mode change
// WAKE  | one-cycle wake pulse, clock enable returning
module ycr_cclk_gate_ch
    import ycr_cclk_pkg::*;
#(
    parameter int unsigned HW = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [1:0]              mode_i,
    input  logic [HW-1:0]           holdoff_i,
    input  logic                    dst_idle_i,
    input  logic                    src_req_i,
    input  logic                    wake_irq_i,
    input  logic                    stats_clr_i,
    output logic                    clk_o,
    output logic                    clk_enb_o,
    output logic                    wakeup_o,
    output logic [CCLK_STATS_W-1:0] gated_cnt_o
);
    cclk_mode_e  mode;
    cclk_state_e state_q, state_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic          off_q;
    logic          enb_q;
    logic          wake_req;

    assign mode     = cclk_mode_e'(mode_i);
    assign wake_req = src_req_i | ((mode == CCLK_AUTO_IRQ) & wake_irq_i);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wakeup_o = (state_q == ST_WAKE);
        if (mode == CCLK_OFF) begin
            state_d = ST_GATED;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cclk_is_auto(mode) && dst_idle_i && !wake_req) begin
                        state_d = ST_HOLD;
                        cnt_d   = holdoff_i;
                    end
                end
                ST_HOLD: begin
                    if (!cclk_is_auto(mode) || !dst_idle_i || wake_req) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == '0) begin
                        state_d = ST_GATED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GATED: begin
                    // off_q catches the cycle right after leaving forced-off.
                    if (off_q || (mode == CCLK_ON) || wake_req) state_d = ST_WAKE;
                end
                ST_WAKE: state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            off_q   <= 1'b0;
            enb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= (mode == CCLK_OFF);
            enb_q   <= (state_q != ST_GATED);
        end
    end

    assign clk_enb_o = enb_q;

`ifdef YCR_CCLK_STATS_EN
    logic [CCLK_STATS_W-1:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (stats_clr_i) begin
            gcnt_d = '0;
        end else if (!enb_q && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) gcnt_q <= '0;
        else          gcnt_q <= gcnt_d;
    end

    assign gated_cnt_o = gcnt_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign gated_cnt_o      = '0;
`endif

    ctech_clk_gate u_cg (
        .CLK  (clk_i),
        .GATE (enb_q),
        .GCLK (clk_o)
    );

endmodule

// File: rtl/ycr_cclk_gate_mc.sv
// Multi-channel core clock-gate controller: reset and irq synchronisers plus NCH gate channels.
// Define YCR_CCLK_STATS_EN to build the per-channel gated-cycle counters.
module ycr_cclk_gate_mc
    import ycr_cclk_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned NIRQ = 8,
    parameter int unsigned HW   = 4
) (
    input  logic                         core_clk_int,
    input  logic                         rst_n,
    input  logic [2*NCH-1:0]             cfg_mode,
    input  logic [HW*NCH-1:0]            cfg_holdoff,
    input  logic [NIRQ*NCH-1:0]          cfg_irq_mask,
    input  logic [NCH-1:0]               dst_idle,
    input  logic [NCH-1:0]               src_req,
    input  logic [NIRQ-1:0]              irq_i,
    input  logic [NCH-1:0]               stats_clr,
    output logic [NCH-1:0]               clk_out,
    output logic [NCH-1:0]               clk_enb,
    output logic [NCH-1:0]               wakeup,
    output logic [CCLK_STATS_W*NCH-1:0]  gated_cnt
);
    logic [1:0]      rst_sync_q;
    logic            rst_core_n;
    logic [NIRQ-1:0] irq_meta_q;
    logic [NIRQ-1:0] irq_ss_q;
    logic [NCH-1:0]  wake_irq;

    // Assert immediately so clocks resume at once; release on the clock.
    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_core_n = rst_sync_q[1];

    always_ff @(posedge core_clk_int or negedge rst_core_n) begin
        if (!rst_core_n) begin
            irq_meta_q <= '0;
            irq_ss_q   <= '0;
        end else begin
            irq_meta_q <= irq_i;
            irq_ss_q   <= irq_meta_q;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wake_irq[i] = |(irq_ss_q & cfg_irq_mask[NIRQ*i +: NIRQ]);

        ycr_cclk_gate_ch #(
            .HW (HW)
        ) u_ch (
            .clk_i       (core_clk_int),
            .rst_n_i     (rst_core_n),
            .mode_i      (cfg_mode[2*i +: 2]),
            .holdoff_i   (cfg_holdoff[HW*i +: HW]),
            .dst_idle_i  (dst_idle[i]),
            .src_req_i   (src_req[i]),
            .wake_irq_i  (wake_irq[i]),
            .stats_clr_i (stats_clr[i]),
            .clk_o       (clk_out[i]),
            .clk_enb_o   (clk_enb[i]),
            .wakeup_o    (wakeup[i]),
            .gated_cnt_o (gated_cnt[CCLK_STATS_W*i +: CCLK_STATS_W])
        );
    end

endmodule

// File: tb/tb_ycr_cclk_gate_mc.sv
// Randomised and directed bench for ycr_cclk_gate_mc against a cycle-level reference model.
module tb_ycr_cclk_gate_mc;
    localparam int NCH  = 4;
    localparam int NIRQ = 8;
    localparam int HW   = 4;
    localparam int SW   = 16;
`ifdef YCR_CCLK_STATS_EN
    localparam int STATS_20 = 20;
`else
    localparam int STATS_20 = 0;
`endif

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [2*NCH-1:0]     cfg_mode;
    logic [HW*NCH-1:0]    cfg_holdoff;
    logic [NIRQ*NCH-1:0]  cfg_irq_mask;
    logic [NCH-1:0]       dst_idle, src_req, stats_clr;
    logic [NIRQ-1:0]      irq_i;
    logic [NCH-1:0]       clk_out, clk_enb, wakeup;
    logic [SW*NCH-1:0]    gated_cnt;

    always #5 clk = ~clk;

    ycr_cclk_gate_mc #(.NCH(NCH), .NIRQ(NIRQ), .HW(HW)) dut (
        .core_clk_int (clk),
        .rst_n        (rst_n),
        .cfg_mode     (cfg_mode),
        .cfg_holdoff  (cfg_holdoff),
        .cfg_irq_mask (cfg_irq_mask),
        .dst_idle     (dst_idle),
        .src_req      (src_req),
        .irq_i        (irq_i),
        .stats_clr    (stats_clr),
        .clk_out      (clk_out),
        .clk_enb      (clk_enb),
        .wakeup       (wakeup),
        .gated_cnt    (gated_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a channel is running, waking or gated; gating happens once
    // the channel has seen holdoff+2 consecutive qualifying (auto, idle, no wake) edges.
    bit  m_gated  [NCH];
    bit  m_waking [NCH];
    bit  m_was_off[NCH];
    bit  m_enb    [NCH];
    int  m_streak [NCH];
    int  m_hlat   [NCH];
    int  m_cnt    [NCH];
    logic [NIRQ-1:0] irq_d1, irq_d2;

    task automatic model_init();
        for (int c = 0; c < NCH; c++) begin
            m_gated[c] = 0; m_waking[c] = 0; m_was_off[c] = 0; m_enb[c] = 1;
            m_streak[c] = 0; m_hlat[c] = 0; m_cnt[c] = 0;
        end
        irq_d1 = '0;
        irq_d2 = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int mode      = int'(cfg_mode[2*c +: 2]);
            bit irq_wake  = |(irq_d2 & cfg_irq_mask[NIRQ*c +: NIRQ]);
            bit wake      = src_req[c] || (mode == 3 && irq_wake);
            bit auto_m    = (mode == 1) || (mode == 3);
            if (stats_clr[c])                          m_cnt[c] = 0;
            else if (!m_enb[c] && m_cnt[c] < 65535)    m_cnt[c]++;
            m_enb[c] = !m_gated[c];
            if (mode == 2) begin
                m_gated[c] = 1; m_waking[c] = 0; m_streak[c] = 0;
            end else if (m_waking[c]) begin
                m_waking[c] = 0; m_streak[c] = 0;
            end else if (m_gated[c]) begin
                if (m_was_off[c] || mode == 0 || wake) begin
                    m_gated[c] = 0; m_waking[c] = 1;
                end
            end else if (auto_m && dst_idle[c] && !wake) begin
                m_streak[c]++;
                if (m_streak[c] == 1) m_hlat[c] = int'(cfg_holdoff[HW*c +: HW]);
                if (m_streak[c] == m_hlat[c] + 2) begin
                    m_gated[c] = 1; m_streak[c] = 0;
                end
            end else begin
                m_streak[c] = 0;
            end
            m_was_off[c] = (mode == 2);
        end
        irq_d2 = irq_d1;
        irq_d1 = irq_i;
    endtask

    function automatic logic [NCH-1:0] exp_enb();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_enb[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_wake();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_waking[c];
        return v;
    endfunction

    function automatic logic [SW*NCH-1:0] exp_cnt();
        logic [SW*NCH-1:0] v;
        v = '0;
`ifdef YCR_CCLK_STATS_EN
        for (int c = 0; c < NCH; c++) v[SW*c +: SW] = SW'(m_cnt[c]);
`endif
        return v;
    endfunction

    // Called at a falling edge with the inputs for the coming rising edge already driven.
    task automatic step();
        logic [NCH-1:0] enb_before;
        enb_before = exp_enb();
        model_edge();
        @(posedge clk);
        #1;
        chk("clk_out", 64'(clk_out), 64'(enb_before));
        @(negedge clk);
        chk("clk_enb", 64'(clk_enb), 64'(exp_enb()));
        chk("wakeup", 64'(wakeup), 64'(exp_wake()));
        chk("gated_cnt", 64'(gated_cnt), 64'(exp_cnt()));
    endtask

    task automatic quiet();
        cfg_mode = '0; cfg_holdoff = '0; cfg_irq_mask = '0;
        dst_idle = '0; src_req = '0; stats_clr = '0; irq_i = '0;
    endtask

    task automatic set_ch(input int c, input int mode, input int hold, input bit idle, input bit req);
        cfg_mode[2*c +: 2]     = 2'(mode);
        cfg_holdoff[HW*c +: HW] = HW'(hold);
        dst_idle[c] = idle;
        src_req[c]  = req;
    endtask

    task automatic do_reset(input bit immediate);
        rst_n = 1'b0;
        quiet();
        if (immediate) begin
            #1;
            chk("rst_async_enb", 64'(clk_enb), 64'({NCH{1'b1}}));
            chk("rst_async_wakeup", 64'(wakeup), 64'(0));
            chk("rst_async_cnt", 64'(gated_cnt), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (immediate || i > 0) chk("rst_clk_out", 64'(clk_out), 64'({NCH{1'b1}}));
            @(negedge clk);
            chk("rst_clk_enb", 64'(clk_enb), 64'({NCH{1'b1}}));
            chk("rst_wakeup", 64'(wakeup), 64'(0));
            chk("rst_gated_cnt", 64'(gated_cnt), 64'(0));
        end
        model_init();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic run_random(input int n_steps);
        for (int s = 0; s < n_steps; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 29) == 0) cfg_mode[2*c +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0)
                    cfg_holdoff[HW*c +: HW] = ($urandom_range(0, 7) == 0) ? HW'($urandom_range(0, 15))
                                                                        : HW'($urandom_range(0, 3));
                dst_idle[c]  = ($urandom_range(0, 9) != 0);
                src_req[c]   = ($urandom_range(0, 19) == 0);
                stats_clr[c] = ($urandom_range(0, 31) == 0);
            end
            for (int b = 0; b < NIRQ; b++) irq_i[b] = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0)
                for (int b = 0; b < NIRQ*NCH; b++) cfg_irq_mask[b] = ($urandom_range(0, 3) == 0);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int wk;
        bit ok;
        quiet();
        #2;
        do_reset(1'b0);

        // ch0: auto, hold-off 3, then source request wake
        set_ch(0, 1, 3, 1, 0);
        n = 0;
        do begin step(); n++; end while (clk_enb[0] && n < 20);
        chk("ch0_gate_latency", 64'(n), 64'(6));
        src_req[0] = 1'b1;
        step();
        src_req[0] = 1'b0;
        chk("ch0_wakeup_pulse", 64'(wakeup[0]), 64'(1));
        chk("ch0_enb_still_low", 64'(clk_enb[0]), 64'(0));
        step();
        chk("ch0_enb_restored", 64'(clk_enb[0]), 64'(1));
        chk("ch0_wakeup_done", 64'(wakeup[0]), 64'(0));
        set_ch(0, 0, 0, 0, 0);
        step();

        // ch1: auto+irq, hold-off 0, irq line 2 masked in then out
        set_ch(1, 3, 0, 1, 0);
        cfg_irq_mask[NIRQ*1 + 2] = 1'b1;
        n = 0;
        do begin step(); n++; end while (clk_enb[1] && n < 20);
        chk("ch1_gate_latency_h0", 64'(n), 64'(3));
        irq_i[2] = 1'b1;
        step();
        irq_i[2] = 1'b0;
        n = 1;
        while (!wakeup[1] && n < 10) begin step(); n++; end
        chk("ch1_irq_wake_latency", 64'(n), 64'(3));
        cfg_irq_mask[NIRQ*1 + 2] = 1'b0;
        n = 0;
        do begin step(); n++; end while (clk_enb[1] && n < 20);
        chk("ch1_regated", 64'(clk_enb[1]), 64'(0));
        irq_i[2] = 1'b1;
        step();
        irq_i[2] = 1'b0;
        wk = int'(wakeup[1]);
        for (int i = 0; i < 6; i++) begin step(); wk += int'(wakeup[1]); end
        chk("ch1_masked_no_wake", 64'(wk), 64'(0));
        set_ch(1, 0, 0, 0, 0);
        step();
        step();

        // ch2: hold-off 5, idle drops while counter is at 2
        set_ch(2, 1, 5, 1, 0);
        ok = 1'b1;
        repeat (4) begin step(); ok &= clk_enb[2]; end
        dst_idle[2] = 1'b0;
        repeat (6) begin step(); ok &= clk_enb[2]; end
        chk("ch2_hold_abort", 64'(ok), 64'(1));
        set_ch(2, 0, 0, 0, 0);
        step();

        // ch3: forced off while requesting, then always-on
        set_ch(3, 2, 0, 0, 1);
        step();
        chk("ch3_off_no_wakeup", 64'(wakeup[3]), 64'(0));
        step();
        chk("ch3_off_enb", 64'(clk_enb[3]), 64'(0));
        wk = 0;
        repeat (3) begin step(); wk += int'(wakeup[3]); end
        chk("ch3_off_ignores_req", 64'(wk), 64'(0));
        set_ch(3, 0, 0, 0, 0);
        step();
        chk("ch3_on_wakeup", 64'(wakeup[3]), 64'(1));
        step();
        chk("ch3_on_enb", 64'(clk_enb[3]), 64'(1));

        // gated-cycle statistics on ch0
        set_ch(0, 1, 0, 1, 0);
        n = 0;
        do begin step(); n++; end while (clk_enb[0] && n < 20);
        stats_clr[0] = 1'b1;
        step();
        stats_clr[0] = 1'b0;
        chk("stats_clr_priority", 64'(gated_cnt[SW-1:0]), 64'(0));
        repeat (20) step();
        chk("stats_20_cycles", 64'(gated_cnt[SW-1:0]), 64'(STATS_20));
        set_ch(0, 0, 0, 0, 0);
        step();
        step();

        run_random(500);
        do_reset(1'b1);
        run_random(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
